// File: rtl/pwm_pkg.sv
// Shared constants, FSM encoding and a saturating increment for the PWM capture block.
package pwm_pkg;

    localparam int CNT_W = 32;

    localparam logic [CNT_W-1:0] CNT_SAT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2
    } pwm_state_e;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for the PWM input plus rising-edge detector.
// All flops reset high so a generator idling high after reset gives no false edge.
module pwm_sync_edge (
    input  logic Clk50M,
    input  logic Rst_n,
    input  logic i_pwm,
    output logic level,
    output logic rise
);

    logic sync_q1;
    logic sync_q2;
    logic prev_q;

    // Synchronize the asynchronous input and keep one older sample for edge detection.
    always_ff @(posedge Clk50M or negedge Rst_n) begin
        if (!Rst_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync_q1 <= i_pwm;
            sync_q2 <= sync_q1;
            prev_q  <= sync_q2;
        end
    end

    assign level = sync_q2;
    assign rise  = sync_q2 & ~prev_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / low-time capture.
// The first rising edge after arming starts a period; every following rising edge
// publishes the finished period as meas_arr = period - 1 and meas_ccr = low cycles.
// A period that runs to timeout_limit cycles without a new edge re-arms the block.
// Handshake: meas_valid and o_timeout are single-cycle strobes with no back-pressure;
// meas_arr/meas_ccr are stable from the meas_valid cycle until the next meas_valid.
module pwm_capture
    import pwm_pkg::*;
(
    input  logic             Clk50M,
    input  logic             Rst_n,
    input  logic             cnt_en,
    input  logic             i_pwm,
    input  logic [CNT_W-1:0] timeout_limit,
    output logic [CNT_W-1:0] meas_arr,
    output logic [CNT_W-1:0] meas_ccr,
    output logic             meas_valid,
    output logic             o_timeout,
    output logic             o_level,
    output pwm_state_e       state_dbg
);

    pwm_state_e       state;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] low_cnt;
    logic             level;
    logic             rise;
    logic             timeout_hit;

    pwm_sync_edge u_sync_edge (
        .Clk50M (Clk50M),
        .Rst_n  (Rst_n),
        .i_pwm  (i_pwm),
        .level  (level),
        .rise   (rise)
    );

    assign o_level     = level;
    assign state_dbg   = state;
    assign timeout_hit = (timeout_limit != '0) && (period_cnt == timeout_limit);

    // Period and low-time counters: restart on each rising edge, saturate otherwise.
    always_ff @(posedge Clk50M or negedge Rst_n) begin
        if (!Rst_n) begin
            period_cnt <= '0;
            low_cnt    <= '0;
        end else if (!cnt_en) begin
            period_cnt <= '0;
            low_cnt    <= '0;
        end else if (rise) begin
            period_cnt <= CNT_W'(1);
            low_cnt    <= '0;
        end else begin
            period_cnt <= sat_inc(period_cnt);
            if (!level) begin
                low_cnt <= sat_inc(low_cnt);
            end
        end
    end

    // Capture FSM with registered result and strobe outputs; a rise beats a timeout.
    always_ff @(posedge Clk50M or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= ST_IDLE;
            meas_arr   <= '0;
            meas_ccr   <= '0;
            meas_valid <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            o_timeout  <= 1'b0;
            if (!cnt_en) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_ARMED;
                    end
                    ST_ARMED: begin
                        if (rise) begin
                            state <= ST_MEASURE;
                        end
                    end
                    ST_MEASURE: begin
                        if (rise) begin
                            meas_arr   <= period_cnt - CNT_W'(1);
                            meas_ccr   <= low_cnt;
                            meas_valid <= 1'b1;
                        end else if (timeout_hit) begin
                            o_timeout <= 1'b1;
                            state     <= ST_ARMED;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: waveforms built from (high, low) cycle pairs, expected
// measurements derived from the period/low-time rules and compared in a scoreboard.
module tb_pwm_capture;
    import pwm_pkg::*;

    logic        Clk50M = 1'b0;
    logic        Rst_n;
    logic        cnt_en;
    logic        i_pwm;
    logic [31:0] timeout_limit;
    logic [31:0] meas_arr;
    logic [31:0] meas_ccr;
    logic        meas_valid;
    logic        o_timeout;
    logic        o_level;
    pwm_state_e  state_dbg;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    int          got_cyc_q[$];
    int          to_cyc_q[$];

    pwm_capture dut (
        .Clk50M        (Clk50M),
        .Rst_n         (Rst_n),
        .cnt_en        (cnt_en),
        .i_pwm         (i_pwm),
        .timeout_limit (timeout_limit),
        .meas_arr      (meas_arr),
        .meas_ccr      (meas_ccr),
        .meas_valid    (meas_valid),
        .o_timeout     (o_timeout),
        .o_level       (o_level),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / cycle count ----------------
    always #10 Clk50M = ~Clk50M;

    always @(posedge Clk50M) cyc <= cyc + 1;

    // Monitor: record every strobe with the clock edge number it followed.
    always @(negedge Clk50M) begin
        if (meas_valid !== 1'b0) begin
            got_q.push_back({meas_arr, meas_ccr});
            got_cyc_q.push_back(cyc);
        end
        if (o_timeout !== 1'b0) to_cyc_q.push_back(cyc);
    end

    // ---------------- driver tasks ----------------
    task automatic prep(input logic [31:0] lim);
        @(negedge Clk50M);
        cnt_en = 1'b0;
        i_pwm = 1'b0;
        timeout_limit = lim;
        repeat (4) @(negedge Clk50M);
        cnt_en = 1'b1;
        repeat (2) @(negedge Clk50M);
        exp_q.delete();
        got_q.delete();
        got_cyc_q.delete();
        to_cyc_q.delete();
    endtask

    // One PWM period starting with its rising edge; the reference result is queued.
    task automatic drive_period(input int hi, input int lo);
        i_pwm = 1'b1;
        repeat (hi) @(negedge Clk50M);
        i_pwm = 1'b0;
        repeat (lo) @(negedge Clk50M);
        exp_q.push_back({32'(hi + lo - 1), 32'(lo)});
    endtask

    task automatic close_rise(output int c);
        c = cyc;
        i_pwm = 1'b1;
        repeat (6) @(negedge Clk50M);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        Rst_n = 1'b0;
        cnt_en = 1'b0;
        i_pwm = 1'b0;
        timeout_limit = 32'd0;
        repeat (3) @(negedge Clk50M);
        tests++; if (meas_arr !== 32'd0) begin fails++; $display("FAIL reset_arr got %0h exp 0", meas_arr); end
        tests++; if (meas_ccr !== 32'd0) begin fails++; $display("FAIL reset_ccr got %0h exp 0", meas_ccr); end
        tests++; if (meas_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", meas_valid); end
        tests++; if (o_timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout got %b exp 0", o_timeout); end
        tests++; if (o_level !== 1'b1) begin fails++; $display("FAIL reset_level got %b exp 1", o_level); end
        tests++; if (state_dbg !== ST_IDLE) begin fails++; $display("FAIL reset_state got %0d exp %0d", state_dbg, ST_IDLE); end
        Rst_n = 1'b1;
        repeat (4) @(negedge Clk50M);
        tests++; if (o_level !== 1'b0) begin fails++; $display("FAIL level_follow got %b exp 0", o_level); end
        tests++; if (state_dbg !== ST_IDLE) begin fails++; $display("FAIL idle_no_en got %0d exp %0d", state_dbg, ST_IDLE); end
    endtask

    task automatic test_loopback;
        int c;
        logic [63:0] g, e;
        prep(32'd0);
        repeat (6) drive_period(7, 3);
        close_rise(c);
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL loop_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 1; i < got_cyc_q.size(); i++) begin
            tests++; if (got_cyc_q[i] - got_cyc_q[i-1] != 10) begin fails++; $display("FAIL loop_interval got %0d exp 10", got_cyc_q[i] - got_cyc_q[i-1]); end
        end
        tests++; if (got_cyc_q.size() == 0 || got_cyc_q[got_cyc_q.size()-1] != c + 3) begin fails++; $display("FAIL valid_latency got %0d exp %0d", (got_cyc_q.size() == 0) ? -1 : got_cyc_q[got_cyc_q.size()-1], c + 3); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            tests++; if (g !== e) begin fails++; $display("FAIL loop_meas got arr=%0d ccr=%0d exp arr=%0d ccr=%0d", g[63:32], g[31:0], e[63:32], e[31:0]); end
        end
    endtask

    task automatic test_random;
        int c;
        logic [63:0] g, e;
        prep(32'd0);
        drive_period(1, 1);
        for (int i = 0; i < 15; i++) drive_period(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)));
        close_rise(c);
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            tests++; if (g !== e) begin fails++; $display("FAIL rand_meas got arr=%0d ccr=%0d exp arr=%0d ccr=%0d", g[63:32], g[31:0], e[63:32], e[31:0]); end
        end
    endtask

    task automatic test_param_change;
        int c;
        logic [63:0] g, e;
        prep(32'd0);
        repeat (3) drive_period(7, 3);
        repeat (3) drive_period(50, 50);
        close_rise(c);
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL param_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            tests++; if (g !== e) begin fails++; $display("FAIL param_meas got arr=%0d ccr=%0d exp arr=%0d ccr=%0d", g[63:32], g[31:0], e[63:32], e[31:0]); end
        end
        tests++; if (meas_arr !== 32'd99 || meas_ccr !== 32'd50) begin fails++; $display("FAIL param_final got arr=%0d ccr=%0d exp arr=99 ccr=50", meas_arr, meas_ccr); end
    endtask

    task automatic test_timeout;
        int c;
        logic [63:0] g, e;
        prep(32'd20);
        repeat (2) drive_period(4, 4);
        c = cyc;
        i_pwm = 1'b1;
        @(negedge Clk50M);
        i_pwm = 1'b0;
        repeat (40) @(negedge Clk50M);
        tests++; if (to_cyc_q.size() != 1) begin fails++; $display("FAIL timeout_count got %0d exp 1", to_cyc_q.size()); end
        tests++; if (to_cyc_q.size() == 0 || to_cyc_q[0] != c + 23) begin fails++; $display("FAIL timeout_when got %0d exp %0d", (to_cyc_q.size() == 0) ? -1 : to_cyc_q[0], c + 23); end
        tests++; if (state_dbg !== ST_ARMED) begin fails++; $display("FAIL timeout_state got %0d exp %0d", state_dbg, ST_ARMED); end
        tests++; if (meas_arr !== 32'd7 || meas_ccr !== 32'd4) begin fails++; $display("FAIL timeout_hold got arr=%0d ccr=%0d exp arr=7 ccr=4", meas_arr, meas_ccr); end
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL timeout_vcount got %0d exp %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            tests++; if (g !== e) begin fails++; $display("FAIL timeout_meas got arr=%0d ccr=%0d exp arr=%0d ccr=%0d", g[63:32], g[31:0], e[63:32], e[31:0]); end
        end
    endtask

    task automatic test_enable_drop;
        int c;
        logic [63:0] g, e;
        prep(32'd0);
        repeat (2) drive_period(8, 4);
        i_pwm = 1'b1;
        repeat (5) @(negedge Clk50M);
        i_pwm = 1'b0;
        repeat (2) @(negedge Clk50M);
        cnt_en = 1'b0;
        repeat (3) @(negedge Clk50M);
        cnt_en = 1'b1;
        repeat (2) @(negedge Clk50M);
        repeat (3) drive_period(5, 5);
        close_rise(c);
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL endrop_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            tests++; if (g !== e) begin fails++; $display("FAIL endrop_meas got arr=%0d ccr=%0d exp arr=%0d ccr=%0d", g[63:32], g[31:0], e[63:32], e[31:0]); end
        end
    endtask

    task automatic test_reset_mid;
        int c;
        logic [63:0] g, e;
        prep(32'd0);
        repeat (2) drive_period(6, 3);
        i_pwm = 1'b1;
        repeat (5) @(negedge Clk50M);
        i_pwm = 1'b0;
        repeat (2) @(negedge Clk50M);
        Rst_n = 1'b0;
        #1;
        tests++; if (meas_arr !== 32'd0 || meas_ccr !== 32'd0) begin fails++; $display("FAIL midrst_meas got arr=%0d ccr=%0d exp 0 0", meas_arr, meas_ccr); end
        tests++; if (meas_valid !== 1'b0 || o_timeout !== 1'b0) begin fails++; $display("FAIL midrst_strobes got %b%b exp 00", meas_valid, o_timeout); end
        tests++; if (o_level !== 1'b1) begin fails++; $display("FAIL midrst_level got %b exp 1", o_level); end
        tests++; if (state_dbg !== ST_IDLE) begin fails++; $display("FAIL midrst_state got %0d exp %0d", state_dbg, ST_IDLE); end
        repeat (2) @(negedge Clk50M);
        Rst_n = 1'b1;
        repeat (4) @(negedge Clk50M);
        repeat (2) drive_period(4, 6);
        close_rise(c);
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL midrst_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            tests++; if (g !== e) begin fails++; $display("FAIL midrst_vals got arr=%0d ccr=%0d exp arr=%0d ccr=%0d", g[63:32], g[31:0], e[63:32], e[31:0]); end
        end
    endtask

    task automatic test_tie;
        int c;
        logic [63:0] g, e;
        prep(32'd10);
        repeat (4) drive_period(5, 5);
        close_rise(c);
        tests++; if (to_cyc_q.size() != 0) begin fails++; $display("FAIL tie_timeout got %0d exp 0", to_cyc_q.size()); end
        tests++; if (got_q.size() != exp_q.size()) begin fails++; $display("FAIL tie_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            tests++; if (g !== e) begin fails++; $display("FAIL tie_meas got arr=%0d ccr=%0d exp arr=%0d ccr=%0d", g[63:32], g[31:0], e[63:32], e[31:0]); end
        end
        tests++; if (state_dbg !== ST_MEASURE) begin fails++; $display("FAIL tie_state got %0d exp %0d", state_dbg, ST_MEASURE); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_loopback();
        test_random();
        test_param_change();
        test_timeout();
        test_enable_drop();
        test_reset_mid();
        test_tie();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 The block SHALL have port Clk50M, input, 1 bit: the single 50 MHz clock; all state changes on its rising edge.
REQ-002 The block SHALL have port Rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port cnt_en, input, 1 bit: capture enable; low forces IDLE.
REQ-004 The block SHALL have port i_pwm, input, 1 bit: asynchronous PWM waveform under measurement.
REQ-005 The block SHALL have port timeout_limit, input, 32 bits: maximum cycles without a rising edge; 0 disables timeout.
REQ-006 The block SHALL have port meas_arr, output, 32 bits: measured period minus 1 (generator preload equivalent).
REQ-007 The block SHALL have port meas_ccr, output, 32 bits: measured low cycles per period (generator compare equivalent).
REQ-008 The block SHALL have port meas_valid, output, 1 bit: one-cycle pulse when meas_arr/meas_ccr update.
REQ-009 The block SHALL have port o_timeout, output, 1 bit: one-cycle pulse on timeout.
REQ-010 The block SHALL have port o_level, output, 1 bit: synchronized i_pwm level.

Function
REQ-011 i_pwm SHALL pass through a 2-flop synchronizer; a rising edge ("rise") is synchronized level 1 while the previous synchronized sample is 0.
REQ-012 The FSM SHALL have states IDLE, ARMED and MEASURE.
REQ-013 IDLE SHALL go to ARMED when cnt_en=1; any state SHALL go to IDLE within one cycle of cnt_en=0, with the measurement in progress discarded and no meas_valid.
REQ-014 ARMED SHALL go to MEASURE on rise, with no meas_valid for that first edge.
REQ-015 On rise, period_cnt SHALL load 1 and low_cnt SHALL load 0; otherwise period_cnt SHALL increment and low_cnt SHALL increment when the synchronized level is 0.
REQ-016 Both counters SHALL saturate at 32'hFFFF_FFFF without wrapping.
REQ-017 On rise in MEASURE, the block SHALL register meas_arr <= period_cnt - 1 and meas_ccr <= low_cnt, pulse meas_valid, and remain in MEASURE.
REQ-018 meas_valid SHALL assert on the 3rd Clk50M rising edge after the i_pwm rise is first sampled.
REQ-019 meas_arr and meas_ccr SHALL hold their values between valid pulses, including through IDLE.
REQ-020 In MEASURE with timeout_limit != 0, when period_cnt == timeout_limit and no rise occurs, the block SHALL pulse o_timeout and go to ARMED.
REQ-021 When rise and timeout occur in the same cycle, rise SHALL win and o_timeout SHALL stay 0.
REQ-022 A period of 1 cycle is not resolvable; the minimum measurable period SHALL be 2 cycles (high and low each at least 1 cycle).
REQ-023 o_level SHALL equal the second synchronizer flop.

Reset
REQ-024 While Rst_n=0, the state SHALL be IDLE; meas_arr, meas_ccr, period_cnt and low_cnt SHALL be 0; meas_valid and o_timeout SHALL be 0.
REQ-025 While Rst_n=0, the synchronizer flops and o_level SHALL be 1, matching the generator's idle-high reset level, so no spurious rise occurs after reset.
REQ-026 Reset asserted mid-measurement SHALL abort immediately, with no pulse on release.

Structure
REQ-027 Package pwm_pkg SHALL hold the counter width (32), the FSM state encoding and the saturation constant.
REQ-028 The synchronizer and edge detector SHALL be one sub-module, pwm_sync_edge, with outputs level and rise.

Verification
REQ-029 Scenario (loopback): pwm_generator with counter_arr=9, counter_ccr=3, cnt_en=1 drives i_pwm -> from the second rise onward, meas_valid every 10 cycles with meas_arr=9 and meas_ccr=3.
REQ-030 Scenario (parameter change): change to counter_arr=99, counter_ccr=50 mid-run -> after at most one transitional period, meas_arr=99 and meas_ccr=50 on every pulse.
REQ-031 Scenario (stuck input): timeout_limit=20, i_pwm held low after one rise -> o_timeout pulses exactly once when period_cnt reaches 20, state goes to ARMED, and meas_arr/meas_ccr keep their old values.
REQ-032 Scenario (enable drop): cnt_en dropped mid-period, then re-raised -> no meas_valid until the second rise after re-enable.
REQ-033 Scenario (reset mid-run): Rst_n pulsed low mid-period -> all outputs are 0 except o_level=1; the first valid pulse occurs only after two rises.
REQ-034 Scenario (tie): rise coincides with period_cnt == timeout_limit=10 (10-cycle period) -> meas_valid=1, o_timeout=0, meas_arr=9.
